reg_share_arb: RTL and testbench

REG_SHARE_ARB -- requirements
Module: reg_share_arb

---
 rtl/reg_share_pkg.sv | 14 +
 rtl/rr_pick.sv | 36 +++
 rtl/reg_share_arb.sv | 115 +++++++++++
 tb/tb_reg_share_arb.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/reg_share_pkg.sv
// rtl/reg_share_pkg.sv - shared types and default parameters for the register-share arbiter
package reg_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int N_REQ_DEF    = 4;
    localparam int WIDTH_DEF    = 8;
    localparam int MAX_HOLD_DEF = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin search starting at ptr, wrapping modulo N_REQ
module rr_pick
    import reg_share_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] idx,
    output logic             found
);

    int               c;
    logic [PTR_W-1:0] cand;

    // Scan from the farthest offset down so the nearest hit to ptr wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        c     = 0;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            c = int'(ptr) + k;
            if (c >= N_REQ) begin
                c = c - N_REQ;
            end
            cand = PTR_W'(c);
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_share_arb.sv
// rtl/reg_share_arb.sv - round-robin arbiter granting one requester write access to a shared register
module reg_share_arb
    import reg_share_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int WIDTH    = WIDTH_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       lock,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic                   reg_en,
    output logic [WIDTH-1:0]       reg_d,
    output logic                   busy
);

    localparam int         PTR_W      = $clog2(N_REQ);
    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               reg_en_q, reg_en_d;
    logic [WIDTH-1:0]   reg_d_q, reg_d_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [7:0]         hold_cnt_q, hold_cnt_d;

    logic [PTR_W-1:0]   pick_idx;
    logic               pick_found;
    logic [PTR_W-1:0]   cur_idx;
    logic [WIDTH-1:0]   wdata_a [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_wdata
        assign wdata_a[i] = wdata[i*WIDTH +: WIDTH];
    end

    rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // The held grant is the burst owner, so its index is recovered from gnt.
    always_comb begin
        cur_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) begin
                cur_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        reg_en_d   = 1'b0;
        reg_d_d    = reg_d_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_found) begin
                    gnt_d[pick_idx] = 1'b1;
                    reg_en_d        = 1'b1;
                    reg_d_d         = wdata_a[pick_idx];
                    ptr_d           = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    hold_cnt_d      = '0;
                    state_d         = lock[pick_idx] ? HOLD : DONE;
                end
            end
            HOLD: begin
                if (req[cur_idx] && lock[cur_idx] && (hold_cnt_q < MAX_HOLD_C)) begin
                    reg_en_d   = 1'b1;
                    reg_d_d    = wdata_a[cur_idx];
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end else begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            reg_en_q   <= 1'b0;
            reg_d_q    <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            reg_en_q   <= reg_en_d;
            reg_d_q    <= reg_d_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt    = gnt_q;
    assign reg_en = reg_en_q;
    assign reg_d  = reg_d_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_reg_share_arb.sv
// tb/tb_reg_share_arb.sv - directed self-checking bench for reg_share_arb
module tb_reg_share_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic        reg_en;
    logic [7:0]  reg_d;
    logic        busy;

    int n_checks;
    int n_pass;

    reg_share_arb #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .lock   (lock),
        .wdata  (wdata),
        .gnt    (gnt),
        .reg_en (reg_en),
        .reg_d  (reg_d),
        .busy   (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] g, input logic en,
                            input logic [7:0] d, input logic b);
        chk({tag, ".gnt"}, 32'(gnt), 32'(g));
        chk({tag, ".reg_en"}, 32'(reg_en), 32'(en));
        chk({tag, ".reg_d"}, 32'(reg_d), 32'(d));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] fair_g [9]  = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    logic [7:0] fair_d [9]  = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'h11};
    logic       fair_b [9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] cap_g  [12] = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h8, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0};
    logic [7:0] cap_d  [12] = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h63, 8'h44,
                                8'h44, 8'h67, 8'h68, 8'h69, 8'h6A, 8'h6A};
    logic       cap_b  [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                                1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        int  run;
        bit  run_done;
        int  writes;

        n_checks = 0;
        n_pass   = 0;
        rst   = 1'b1;
        req   = 4'hF;
        lock  = 4'h0;
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        #2;
        chk_outs("rst_t0", 4'h0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_outs("rst_hold", 4'h0, 1'b0, 8'h00, 1'b0);
        end

        // Release reset with every requester asking: strict rotation, one idle cycle between grants.
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk_outs($sformatf("fair%0d", i), fair_g[i], fair_g[i] != 4'h0, fair_d[i], fair_b[i]);
        end

        req = 4'h0;
        rst = 1'b1;
        #1;
        chk_outs("rst_async_done", 4'h0, 1'b0, 8'h00, 1'b0);
        chk("rst_ptr", 32'(dut.ptr_q), 32'd0);
        tick();
        rst = 1'b0;
        req = 4'b0100;
        wdata[23:16] = 8'hA5;
        tick();
        chk_outs("single_gnt", 4'b0100, 1'b1, 8'hA5, 1'b1);
        req = 4'h0;
        tick();
        chk_outs("single_done", 4'h0, 1'b0, 8'hA5, 1'b0);
        chk("single_ptr", 32'(dut.ptr_q), 32'd3);
        tick();
        chk_outs("single_idle", 4'h0, 1'b0, 8'hA5, 1'b0);

        // Position ptr at 1 with a one-shot grant to requester 0 (also exercises ptr wrap 3 -> 0).
        req = 4'b0001;
        tick();
        chk_outs("wrap_gnt", 4'b0001, 1'b1, 8'h11, 1'b1);
        req = 4'h0;
        tick();
        chk("wrap_ptr", 32'(dut.ptr_q), 32'd1);

        req  = 4'b1010;
        lock = 4'b0010;
        run      = 0;
        run_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            wdata[15:8] = 8'h60 + 8'(i);
            tick();
            chk_outs($sformatf("cap%0d", i), cap_g[i], cap_g[i] != 4'h0, cap_d[i], cap_b[i]);
            if (!run_done && reg_en && gnt == 4'b0010) begin
                run++;
            end else begin
                run_done = 1'b1;
            end
        end
        chk("cap_burst_len", 32'(run), 32'd4);
        req  = 4'h0;
        lock = 4'h0;
        wdata[15:8] = 8'h22;
        tick();
        chk_outs("cap_after", 4'h0, 1'b0, 8'h6A, 1'b0);

        // Early release: requester 0 drops req after its second write.
        req    = 4'b0001;
        lock   = 4'b0001;
        writes = 0;
        tick();
        chk_outs("early_w1", 4'b0001, 1'b1, 8'h11, 1'b1);
        writes += int'(reg_en);
        tick();
        chk_outs("early_w2", 4'b0001, 1'b1, 8'h11, 1'b1);
        writes += int'(reg_en);
        req = 4'h0;
        tick();
        chk_outs("early_rel", 4'h0, 1'b0, 8'h11, 1'b0);
        writes += int'(reg_en);
        chk("early_writes", 32'(writes), 32'd2);
        lock = 4'h0;

        // Reset lands in the second cycle of a locked burst on requester 2.
        req  = 4'b0100;
        lock = 4'b0100;
        tick();
        chk_outs("hrst_w1", 4'b0100, 1'b1, 8'hA5, 1'b1);
        tick();
        chk_outs("hrst_w2", 4'b0100, 1'b1, 8'hA5, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_outs("hrst_async", 4'h0, 1'b0, 8'h00, 1'b0);
        chk("hrst_ptr", 32'(dut.ptr_q), 32'd0);
        req  = 4'h0;
        lock = 4'h0;
        tick();
        chk_outs("hrst_held", 4'h0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_outs($sformatf("hrst_post%0d", i), 4'h0, 1'b0, 8'h00, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
